// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// default index width and saturating counter helpers.
package bp_pkg;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    localparam int IDX_W_DEF = 4;

    function automatic logic [1:0] ctr_inc(input logic [1:0] ctr);
        return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] ctr);
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_array.sv
// BTB storage: one combinational lookup port, an unconditional (ID) write
// port and a counter-training (EX) write port; ID wins on an index collision.
module btb_array
    import bp_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             rd_hit_o,
    output logic [1:0]       rd_ctr_o,
    output logic [31:0]      rd_target_o,
    input  logic             id_we_i,
    input  logic [IDX_W-1:0] id_idx_i,
    input  logic [TAG_W-1:0] id_tag_i,
    input  logic [31:0]      id_target_i,
    input  logic             ex_we_i,
    input  logic [IDX_W-1:0] ex_idx_i,
    input  logic [TAG_W-1:0] ex_tag_i,
    input  logic [31:0]      ex_target_i,
    input  logic             ex_taken_i
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic ex_hit_s;
    logic ex_blocked_s;

    // Lookup and EX hit detection both see the pre-update table.
    always_comb begin
        rd_hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
        rd_ctr_o     = ctr_q[rd_idx_i];
        rd_target_o  = target_q[rd_idx_i];
        ex_hit_s     = valid_q[ex_idx_i] && (tag_q[ex_idx_i] == ex_tag_i);
        ex_blocked_s = id_we_i && (id_idx_i == ex_idx_i);
    end

    // Table update: EX training first, then the ID write so it overrides.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= CTR_SNT;
            end
        end else begin
            if (ex_we_i && !ex_blocked_s) begin
                if (ex_hit_s) begin
                    if (ex_taken_i) begin
                        ctr_q[ex_idx_i]    <= ctr_inc(ctr_q[ex_idx_i]);
                        target_q[ex_idx_i] <= ex_target_i;
                    end else begin
                        ctr_q[ex_idx_i] <= ctr_dec(ctr_q[ex_idx_i]);
                    end
                end else if (ex_taken_i) begin
                    valid_q[ex_idx_i]  <= 1'b1;
                    tag_q[ex_idx_i]    <= ex_tag_i;
                    target_q[ex_idx_i] <= ex_target_i;
                    ctr_q[ex_idx_i]    <= CTR_WT;
                end
            end
            if (id_we_i) begin
                valid_q[id_idx_i]  <= 1'b1;
                tag_q[id_idx_i]    <= id_tag_i;
                target_q[id_idx_i] <= id_target_i;
                ctr_q[id_idx_i]    <= CTR_ST;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with IF->ID->EX PC bookkeeping.
// Optional perf counters are built when BRANCH_PREDICTOR_PERF_EN is defined.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_if,
    input  logic        stall_pc,
    input  logic        stall_id,
    input  logic        flush_id,
    output logic        jump_taken_predict,
    output logic [31:0] predict_target,
    input  logic        uncond_jump_instr,
    input  logic [31:0] uncond_target_id,
    input  logic        cond_jump_instr,
    input  logic [31:0] cond_target_id,
    input  logic        cond_jump_taken_ex,
    input  logic        cond_jump_predict_fail_ex,
    output logic [31:0] perf_lookup_hits,
    output logic [31:0] perf_cond_updates,
    output logic [31:0] perf_mispredicts
);

    localparam int TAG_W = 30 - IDX_W;

    function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
        return pc[31:IDX_W+2];
    endfunction

    logic [31:0] pc_id_q, pc_id_d;
    logic        ex_vld_q, ex_vld_d;
    logic [31:0] pc_ex_q, pc_ex_d;
    logic [31:0] tgt_ex_q, tgt_ex_d;

    logic        rd_hit_s;
    logic [1:0]  rd_ctr_s;
    logic [31:0] rd_target_s;
    logic        id_we_s;

    btb_array #(
        .IDX_W(IDX_W),
        .TAG_W(TAG_W)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (pc_idx(pc_if)),
        .rd_tag_i   (pc_tag(pc_if)),
        .rd_hit_o   (rd_hit_s),
        .rd_ctr_o   (rd_ctr_s),
        .rd_target_o(rd_target_s),
        .id_we_i    (id_we_s),
        .id_idx_i   (pc_idx(pc_id_q)),
        .id_tag_i   (pc_tag(pc_id_q)),
        .id_target_i(uncond_target_id),
        .ex_we_i    (ex_vld_q),
        .ex_idx_i   (pc_idx(pc_ex_q)),
        .ex_tag_i   (pc_tag(pc_ex_q)),
        .ex_target_i(tgt_ex_q),
        .ex_taken_i (cond_jump_taken_ex)
    );

    // Prediction outputs and pipeline next-state; a stalled ID drops ex_vld.
    always_comb begin
        jump_taken_predict = rd_hit_s && rd_ctr_s[1];
        predict_target     = rd_hit_s ? rd_target_s : 32'd0;
        id_we_s            = uncond_jump_instr && !stall_id;

        if (stall_pc) begin
            pc_id_d = pc_id_q;
        end else if (flush_id) begin
            pc_id_d = 32'd0;
        end else begin
            pc_id_d = pc_if;
        end

        if (stall_id) begin
            ex_vld_d = 1'b0;
            pc_ex_d  = pc_ex_q;
            tgt_ex_d = tgt_ex_q;
        end else begin
            ex_vld_d = cond_jump_instr;
            pc_ex_d  = pc_id_q;
            tgt_ex_d = cond_target_id;
        end
    end

    // IF->ID->EX bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_id_q  <= 32'd0;
            ex_vld_q <= 1'b0;
            pc_ex_q  <= 32'd0;
            tgt_ex_q <= 32'd0;
        end else begin
            pc_id_q  <= pc_id_d;
            ex_vld_q <= ex_vld_d;
            pc_ex_q  <= pc_ex_d;
            tgt_ex_q <= tgt_ex_d;
        end
    end

`ifdef BRANCH_PREDICTOR_PERF_EN
    logic [31:0] hits_q, updates_q, mispred_q;

    // Wrapping event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_q    <= 32'd0;
            updates_q <= 32'd0;
            mispred_q <= 32'd0;
        end else begin
            hits_q    <= hits_q + {31'd0, jump_taken_predict && !stall_pc};
            updates_q <= updates_q + {31'd0, ex_vld_q};
            mispred_q <= mispred_q + {31'd0, cond_jump_predict_fail_ex};
        end
    end

    assign perf_lookup_hits  = hits_q;
    assign perf_cond_updates = updates_q;
    assign perf_mispredicts  = mispred_q;

    logic unused_bits_s;
    assign unused_bits_s = ^{pc_if[1:0], pc_id_q[1:0], pc_ex_q[1:0], rd_ctr_s[0]};
`else
    assign perf_lookup_hits  = 32'd0;
    assign perf_cond_updates = 32'd0;
    assign perf_mispredicts  = 32'd0;

    logic unused_bits_s;
    assign unused_bits_s = ^{pc_if[1:0], pc_id_q[1:0], pc_ex_q[1:0], rd_ctr_s[0],
                             cond_jump_predict_fail_ex};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor: each row drives one cycle
// of inputs and checks the combinational lookup before the next clock edge.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_if;
    logic        stall_pc, stall_id, flush_id;
    logic        jump_taken_predict;
    logic [31:0] predict_target;
    logic        uncond_jump_instr;
    logic [31:0] uncond_target_id;
    logic        cond_jump_instr;
    logic [31:0] cond_target_id;
    logic        cond_jump_taken_ex;
    logic        cond_jump_predict_fail_ex;
    logic [31:0] perf_lookup_hits, perf_cond_updates, perf_mispredicts;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk                      (clk),
        .rst                      (rst),
        .pc_if                    (pc_if),
        .stall_pc                 (stall_pc),
        .stall_id                 (stall_id),
        .flush_id                 (flush_id),
        .jump_taken_predict       (jump_taken_predict),
        .predict_target           (predict_target),
        .uncond_jump_instr        (uncond_jump_instr),
        .uncond_target_id         (uncond_target_id),
        .cond_jump_instr          (cond_jump_instr),
        .cond_target_id           (cond_target_id),
        .cond_jump_taken_ex       (cond_jump_taken_ex),
        .cond_jump_predict_fail_ex(cond_jump_predict_fail_ex),
        .perf_lookup_hits         (perf_lookup_hits),
        .perf_cond_updates        (perf_cond_updates),
        .perf_mispredicts         (perf_mispredicts)
    );

    typedef struct {
        logic [31:0] pc;
        logic        spc;
        logic        sid;
        logic        fl;
        logic        un;
        logic [31:0] utgt;
        logic        cd;
        logic [31:0] ctgt;
        logic        tk;
        logic        ep;
        logic [31:0] et;
    } step_t;

    step_t steps[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic add(input logic [31:0] pc, input logic spc, input logic sid,
                       input logic fl, input logic un, input logic [31:0] utgt,
                       input logic cd, input logic [31:0] ctgt, input logic tk,
                       input logic ep, input logic [31:0] et);
        step_t s;
        s.pc = pc; s.spc = spc; s.sid = sid; s.fl = fl; s.un = un; s.utgt = utgt;
        s.cd = cd; s.ctgt = ctgt; s.tk = tk; s.ep = ep; s.et = et;
        steps.push_back(s);
    endtask

    task automatic idle(input logic [31:0] pc, input logic ep, input logic [31:0] et);
        add(pc, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, ep, et);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        stall_pc = 1'b0; stall_id = 1'b0; flush_id = 1'b0;
        uncond_jump_instr = 1'b0; uncond_target_id = 32'd0;
        cond_jump_instr = 1'b0; cond_target_id = 32'd0;
        cond_jump_taken_ex = 1'b0; cond_jump_predict_fail_ex = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        pc_if = 32'd0;
        drive_idle();
        @(negedge clk);
        #1;
        chk("reset_pred", {31'd0, jump_taken_predict}, 32'd0);
        chk("reset_tgt", predict_target, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Lookup miss, then j at 0x00400020
        idle(32'h00400010, 1'b0, 32'd0);
        idle(32'h00400020, 1'b0, 32'd0);
        add(32'h00400020, 0, 0, 0, 1, 32'h00400100, 0, 32'd0, 0, 1'b0, 32'd0);
        idle(32'h00400020, 1'b1, 32'h00400100);
        // beq at 0x00400040: taken x3 (ctr 2,3,3), not-taken x2 (ctr 1)
        idle(32'h00400040, 1'b0, 32'd0);
        add(32'h00400040, 0, 0, 0, 0, 32'd0, 1, 32'h00400080, 0, 1'b0, 32'd0);
        add(32'h00400040, 0, 0, 0, 0, 32'd0, 1, 32'h00400080, 1, 1'b0, 32'd0);
        add(32'h00400040, 0, 0, 0, 0, 32'd0, 1, 32'h00400080, 1, 1'b1, 32'h00400080);
        add(32'h00400040, 0, 0, 0, 0, 32'd0, 0, 32'd0, 1, 1'b1, 32'h00400080);
        add(32'h00400040, 0, 0, 0, 0, 32'd0, 1, 32'h00400080, 0, 1'b1, 32'h00400080);
        add(32'h00400040, 0, 0, 0, 0, 32'd0, 1, 32'h00400080, 0, 1'b1, 32'h00400080);
        add(32'h00400040, 0, 0, 0, 0, 32'd0, 0, 32'd0, 0, 1'b1, 32'h00400080);
        idle(32'h00400040, 1'b0, 32'h00400080);
        // bne at 0x00400060 not taken on a miss: no allocation
        idle(32'h00400060, 1'b0, 32'd0);
        add(32'h00400060, 0, 0, 0, 0, 32'd0, 1, 32'h00400000, 0, 1'b0, 32'd0);
        idle(32'h00400060, 1'b0, 32'd0);
        idle(32'h00400060, 1'b0, 32'd0);
        idle(32'h00400020, 1'b1, 32'h00400100);
        // Alias on index 0: 0x00400080 replaces 0x00400040
        idle(32'h00400080, 1'b0, 32'd0);
        add(32'h00400080, 0, 0, 0, 0, 32'd0, 1, 32'h00400300, 0, 1'b0, 32'd0);
        add(32'h00400080, 0, 0, 0, 0, 32'd0, 0, 32'd0, 1, 1'b0, 32'd0);
        idle(32'h00400040, 1'b0, 32'd0);
        idle(32'h00400080, 1'b1, 32'h00400300);
        // Same-cycle ID j (0x00400004) and EX taken beq (0x00400044), index 1
        idle(32'h00400044, 1'b0, 32'd0);
        add(32'h00400004, 0, 0, 0, 0, 32'd0, 1, 32'h00400400, 0, 1'b0, 32'd0);
        add(32'h00400004, 0, 0, 0, 1, 32'h00400200, 0, 32'd0, 1, 1'b0, 32'd0);
        idle(32'h00400044, 1'b0, 32'd0);
        idle(32'h00400004, 1'b1, 32'h00400200);
        // One not-taken from ST keeps predicting taken
        add(32'h00400004, 0, 0, 0, 0, 32'd0, 1, 32'h00400200, 0, 1'b1, 32'h00400200);
        add(32'h00400004, 0, 0, 0, 0, 32'd0, 0, 32'd0, 0, 1'b1, 32'h00400200);
        idle(32'h00400004, 1'b1, 32'h00400200);
        // Stall 3 cycles with cond_jump_instr: pc_id holds, no EX update
        idle(32'h00400090, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++)
            add(32'h000000F0, 1, 1, 0, 0, 32'd0, 1, 32'h00400500, 1, 1'b0, 32'd0);
        add(32'h00400090, 0, 0, 0, 1, 32'h00400600, 0, 32'd0, 0, 1'b0, 32'd0);
        idle(32'h00400090, 1'b1, 32'h00400600);
        idle(32'h000000F0, 1'b0, 32'd0);
        idle(32'h00400004, 1'b1, 32'h00400200);
        // Flush loads pc_id with 0
        add(32'h00400050, 0, 0, 1, 0, 32'd0, 0, 32'd0, 0, 1'b0, 32'd0);
        add(32'h00400050, 0, 0, 0, 1, 32'h00400700, 0, 32'd0, 0, 1'b0, 32'd0);
        idle(32'h00400080, 1'b0, 32'd0);
        idle(32'h00000000, 1'b1, 32'h00400700);
        idle(32'h00400050, 1'b0, 32'd0);

        for (int i = 0; i < steps.size(); i++) begin
            @(negedge clk);
            pc_if              = steps[i].pc;
            stall_pc           = steps[i].spc;
            stall_id           = steps[i].sid;
            flush_id           = steps[i].fl;
            uncond_jump_instr  = steps[i].un;
            uncond_target_id   = steps[i].utgt;
            cond_jump_instr    = steps[i].cd;
            cond_target_id     = steps[i].ctgt;
            cond_jump_taken_ex = steps[i].tk;
            #1;
            chk($sformatf("step%0d_pred", i), {31'd0, jump_taken_predict}, {31'd0, steps[i].ep});
            chk($sformatf("step%0d_tgt", i), predict_target, steps[i].et);
        end

        // Async reset pulse between clock edges clears hits immediately
        @(negedge clk);
        drive_idle();
        pc_if = 32'h00000000;
        #1;
        chk("pre_rst_pred", {31'd0, jump_taken_predict}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_pred", {31'd0, jump_taken_predict}, 32'd0);
        chk("mid_rst_tgt", predict_target, 32'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        pc_if = 32'h00400004;
        #1;
        chk("post_rst_pred_04", {31'd0, jump_taken_predict}, 32'd0);
        chk("post_rst_tgt_04", predict_target, 32'd0);
        pc_if = 32'h00400020;
        #1;
        chk("post_rst_pred_20", {31'd0, jump_taken_predict}, 32'd0);
        chk("post_rst_tgt_20", predict_target, 32'd0);
`ifndef BRANCH_PREDICTOR_PERF_EN
        chk("perf_hits_tied", perf_lookup_hits, 32'd0);
        chk("perf_upd_tied", perf_cond_updates, 32'd0);
        chk("perf_misp_tied", perf_mispredicts, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Sits beside gen_pc in the IF stage. Looks up the fetch PC combinationally and returns jump_taken_predict plus the predicted target to gen_pc and ctrl.
- Trains from ctrl's branch-predictor interface:
  - unconditional jumps are resolved in ID;
  - conditional branches (beq/bne) are resolved in EX.
- Owns the IF->ID->EX PC/target bookkeeping needed to update the entry of the branch that resolved.

Parameters:
- IDX_W, 4, index width; the BTB has 2**IDX_W entries, index = pc[IDX_W+1:2].
- TAG_W, 30-IDX_W, tag width, tag = pc[31:IDX_W+2]. Derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pc_if  in  32  fetch PC
- stall_pc  in  1  IF frozen (from ctrl)
- stall_id  in  1  ID frozen (from ctrl)
- flush_id  in  1  ID receives a NOP next cycle (from ctrl)
- jump_taken_predict  out  1  BTB hit and counter[1]
- predict_target  out  32  target of the hit entry, 0 on miss
- uncond_jump_instr  in  1  ID holds j/jal/jr (from ctrl)
- uncond_target_id  in  32  resolved target of the ID jump
- cond_jump_instr  in  1  ID holds beq/bne (from ctrl)
- cond_target_id  in  32  branch target computed in ID
- cond_jump_taken_ex  in  1  EX branch outcome (from ctrl)
- cond_jump_predict_fail_ex  in  1  EX mispredict (from ctrl; perf only)
- perf_lookup_hits  out  32  see Optional Feature
- perf_cond_updates  out  32  see Optional Feature
- perf_mispredicts  out  32  see Optional Feature

Behaviour:
- Storage per entry: valid, tag[TAG_W], target[32], ctr[1:0].
- Counter encoding: 0 = SNT, 1 = WNT, 2 = WT, 3 = ST.
- Reset (async, any time including mid-update):
  - all valid = 0, ctr = 0, targets = 0;
  - pipeline registers = 0;
  - outputs therefore 0.
- Lookup (combinational, 0 latency from pc_if):
  - hit = valid[idx] & tag match;
  - jump_taken_predict = hit & ctr[1];
  - predict_target = hit ? target : 0.
  - Reads see pre-update table contents. No same-cycle write bypass.
- pc_id register:
  - loads pc_if on each clk when ~stall_pc;
  - holds while stall_pc;
  - loads 0 when flush_id & ~stall_pc.
- ID update (uncond_jump_instr & ~stall_id), written at next edge:
  - entry[idx(pc_id)] <= valid = 1, tag(pc_id), uncond_target_id, ctr = ST.
- ID->EX capture, when ~stall_id:
  - ex_vld <= cond_jump_instr;
  - pc_ex <= pc_id;
  - tgt_ex <= cond_target_id.
- When stall_id: ex_vld <= 0. This matches ctrl clearing cond_jump_taken_ex on stall.
- EX update, when ex_vld, written at next edge:
  - hit, taken: ctr = min(ctr+1, 3), target <= tgt_ex.
  - hit, not taken: ctr = max(ctr-1, 0).
  - miss, taken: allocate with tag(pc_ex), tgt_ex, ctr = WT. Any aliased entry is overwritten.
  - miss, not taken: no change.
- Same-cycle ID and EX writes to the same index: the ID (unconditional) write wins entirely.
- Different indices: both writes are performed in the same edge.
- Write-port count: the table needs two write ports and one read port.

Optional Feature:
- Macro: BRANCH_PREDICTOR_PERF_EN.
- Defined: three 32-bit wrapping counters, reset to 0, each incrementing by 1 per cycle in which its condition holds:
  - perf_lookup_hits: jump_taken_predict & ~stall_pc;
  - perf_cond_updates: ex_vld;
  - perf_mispredicts: cond_jump_predict_fail_ex.
- Undefined: the counters are not built, and all three ports are tied to 0.

Decomposition:
- Shared package bp_pkg holds:
  - counter encodings CTR_SNT/CTR_WNT/CTR_WT/CTR_ST;
  - default IDX_W;
  - functions ctr_inc/ctr_dec (saturating).
- One sub-module: btb_array. It is the storage, with one combinational read port and two prioritized synchronous write ports.
- The predictor top keeps the pipeline registers, update decode and perf counters.

Test Plan:
- Reset, then pc_if=0x00400010 -> jump_taken_predict=0, predict_target=0.
- j at pc 0x00400020 in ID, uncond_target_id=0x00400100 -> next cycle pc_if=0x00400020 gives predict=1, target=0x00400100.
- beq at 0x00400040, target 0x00400080:
  - taken three times -> ctr 2, then 3, then 3, predict=1;
  - then not-taken twice -> ctr 1, predict=0.
- bne at 0x00400060 resolved not-taken on a miss -> entry stays invalid; lookup of 0x00400060 returns predict=0.
- Alias, IDX_W=4: 0x00400040 allocated, then taken branch at 0x00400080 (same idx 0, different tag) -> 0x00400040 misses, 0x00400080 hits.
- Same-cycle ID j at pc 0x00400004 (target 0x00400200) and EX taken beq at 0x00400044 (both idx 1) -> entry holds tag of 0x00400004, target 0x00400200, ctr=ST.
- Stall and reset:
  - stall_pc=stall_id=1 for 3 cycles with cond_jump_instr=1 -> pc_id held, no EX update.
  - Async rst pulse mid-stream clears all hits within the same cycle.
